obufds_gt_refclk_ctrl: RTL and testbench
========================================

OBUFDS_GT_REFCLK_CTRL -- requirements
Module: obufds_gt_refclk_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, sets the number of independent differential reference-clock output channels (range 1..16).
REQ-002 Parameter REFCLK_EN_TX_PATH [NUM_CH-1:0], default all ones, is a per-channel TX path enable mask; a bit set to 0 disables that channel permanently.
REQ-003 Parameter SETTLE_CYCLES, default 16, sets the wake-up settle and drain-timeout length in CLK cycles (range 1..255).
REQ-004 Parameter SYNC_STAGES, default 2, sets the number of CEB synchroniser flops (range 2..3).
REQ-005 The ports SHALL be, one per line, as follows.
- CLK  input  1  single block clock; all state advances on the rising edge.
- RSTB  input  1  reset, asynchronous, active-low.
- GTS  input  1  global tristate, asynchronous, active-high.
- CEB  input  NUM_CH  per-channel enable request, active-low, asynchronous to CLK.
- I  input  NUM_CH  per-channel clock to be forwarded.
- O  output  NUM_CH  true output; high-Z when the channel is not driving.
- OB  output  NUM_CH  complement output; high-Z when the channel is not driving.
- ACTIVE  output  NUM_CH  channel state is ON.
- BUSY  output  1  at least one channel is in WAKE or DRAIN.

Function
REQ-006 Each CEB bit SHALL pass through SYNC_STAGES flops that reset to 1; the synchronised value is ceb_s.
REQ-007 Each channel SHALL run its own FSM with four states, encoded OFF=00, WAKE=01, ON=10, DRAIN=11, and an 8-bit down-counter.
REQ-008 In OFF, if ceb_s=0 and the mask bit is 1, the FSM SHALL go to WAKE and load the counter with SETTLE_CYCLES-1; otherwise it SHALL stay in OFF.
REQ-009 In WAKE, if ceb_s=1 the FSM SHALL return to OFF immediately, so the output is never driven.
REQ-010 In WAKE, if ceb_s=0, the FSM SHALL go to ON when the counter is 0 and SHALL decrement the counter otherwise.
REQ-011 In ON, if ceb_s=1 the FSM SHALL go to DRAIN and load the counter with SETTLE_CYCLES-1.
REQ-012 In DRAIN, the FSM SHALL apply these rules in priority order: if ceb_s=0, go to ON; else if I sampled at 0, go to OFF; else if the counter is 0, go to OFF (timeout for a stuck-high clock); else decrement the counter.
REQ-013 When the state is ON or DRAIN and GTS=0, the channel SHALL drive O=I and OB=~I combinationally, with zero CLK latency; otherwise O and OB SHALL both be Z.
REQ-014 GTS SHALL override the outputs only; it SHALL NOT alter FSM state, counters or ACTIVE.
REQ-015 ACTIVE[ch] SHALL be a decode of the registered state (state==ON); BUSY SHALL be the OR of WAKE/DRAIN across all channels.
REQ-016 With CEB held low, the latency from a CEB fall to O driven SHALL be SYNC_STAGES+SETTLE_CYCLES+1 CLK rising edges.
REQ-017 Channels SHALL be fully independent; simultaneous requests on several channels SHALL each see the REQ-016 latency.

Reset
REQ-018 Asserting RSTB=0 SHALL asynchronously force all FSMs to OFF, counters to 0, synchronisers to 1, ACTIVE=0, BUSY=0 and O/OB=Z, including mid-WAKE or mid-DRAIN.
REQ-019 After RSTB rises, channels SHALL begin leaving OFF no earlier than the first CLK edge.

Structure
REQ-020 Package obufds_gt_pkg SHALL hold the state encoding enum and the counter width constant (8).
REQ-021 Sub-module obufds_gt_ch SHALL contain one channel's synchroniser, FSM, counter and output drivers, and SHALL be instantiated NUM_CH times by a generate loop.

Verification
All scenarios use NUM_CH=4, SETTLE_CYCLES=16, SYNC_STAGES=2, with I toggling at CLK/4.
REQ-022 CEB[0] falls -> O[0]/OB[0] driven and ACTIVE[0]=1 at rising edge 19; BUSY=1 from edge 3 to edge 18.
REQ-023 CEB[1] low for 8 cycles, then high -> O[1] stays Z throughout; the FSM returns to OFF and BUSY=0 within 3 edges of the CEB rise.
REQ-024 Ch0 ON, CEB[0] rises while I[0] is held at 1 for 5 cycles, then I[0]=0 -> O[0] stays driven until the first edge that samples I[0]=0, then goes Z; also cover CEB re-lowered during DRAIN -> returns to ON with no Z gap.
REQ-025 Ch2 ON, CEB[2] rises with I[2] stuck at 1 -> DRAIN times out and O[2] goes Z after 16 edges.
REQ-026 GTS pulses high for 10 cycles while ch0 is ON -> O/OB=Z immediately and ACTIVE[0] stays 1; driving resumes when GTS falls.
REQ-027 RSTB pulses low mid-WAKE -> all outputs Z and ACTIVE=0 asynchronously; separately, with REFCLK_EN_TX_PATH=4'b0111 and CEB[3]=0, O[3] stays Z indefinitely.

Source files
------------

// File: rtl/obufds_gt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obufds_gt_pkg
// Description : Shared definitions for the GT reference-clock output buffer
//               controller: per-channel state encoding and counter width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package obufds_gt_pkg;

    // Width of the per-channel settle / drain-timeout down-counter.
    localparam int c_cnt_w = 8;

    // Per-channel state. The encoding is fixed so that bit 1 alone means
    // "output path may drive" (ON, DRAIN).
    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WAKE  = 2'b01,
        ST_ON    = 2'b10,
        ST_DRAIN = 2'b11
    } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/obufds_gt_ch.sv
`default_nettype none
// ============================================================================
// Module      : obufds_gt_ch
// Description : One reference-clock output channel: CEB synchroniser,
//               OFF/WAKE/ON/DRAIN sequencer with settle/timeout counter,
//               and the tristate differential output drivers.
// Ports       : clk, rst_n      - block clock, async active-low reset
//               i_gts           - global tristate (outputs only)
//               i_ceb           - enable request, active-low, asynchronous
//               i_refclk        - clock to forward
//               o_p / o_n       - true / complement output, Z when idle
//               o_active        - state is ON
//               o_busy          - state is WAKE or DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
module obufds_gt_ch
    import obufds_gt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2,
    parameter bit TX_PATH_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_gts,
    input  logic i_ceb,
    input  logic i_refclk,
    output logic o_p,
    output logic o_n,
    output logic o_active,
    output logic o_busy
);

    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ceb_s;
    ch_state_t              r_state;
    ch_state_t              w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   w_drive;

    // Synchroniser resets to 1 so a channel cannot start waking until CEB
    // has been seen low through every stage after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ceb};
        end
    end

    assign w_ceb_s = r_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_OFF: begin
                if (!w_ceb_s && TX_PATH_EN) begin
                    w_state_nxt = ST_WAKE;
                    w_cnt_nxt   = c_settle_load;
                end
            end
            ST_WAKE: begin
                // Aborting a wake never passes through a driving state.
                if (w_ceb_s) begin
                    w_state_nxt = ST_OFF;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            ST_ON: begin
                if (w_ceb_s) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = c_settle_load;
                end
            end
            ST_DRAIN: begin
                // Stop on a low clock phase so the output is released
                // without a runt pulse; the counter only covers a clock
                // that is stuck high.
                if (!w_ceb_s) begin
                    w_state_nxt = ST_ON;
                end else if (!i_refclk) begin
                    w_state_nxt = ST_OFF;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // Output decode
    always_comb begin
        w_drive  = 1'b0;
        o_active = 1'b0;
        o_busy   = 1'b0;
        case (r_state)
            ST_WAKE:  o_busy = 1'b1;
            ST_ON: begin
                w_drive  = 1'b1;
                o_active = 1'b1;
            end
            ST_DRAIN: begin
                w_drive = 1'b1;
                o_busy  = 1'b1;
            end
            default: w_drive = 1'b0;
        endcase
    end

    // GTS gates only the drivers, never the sequencer.
    assign o_p = (w_drive && !i_gts) ? i_refclk  : 1'bz;
    assign o_n = (w_drive && !i_gts) ? ~i_refclk : 1'bz;

endmodule
`default_nettype wire

// File: rtl/obufds_gt_refclk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : obufds_gt_refclk_ctrl
// Description : NUM_CH independent differential reference-clock output
//               buffers with synchronised enable, settle and drain control.
// Ports       : CLK    - block clock
//               RSTB   - asynchronous active-low reset
//               GTS    - global tristate, forces all outputs to Z
//               CEB    - per-channel enable request, active-low
//               I      - per-channel clock to forward
//               O / OB - per-channel true / complement output, Z when idle
//               ACTIVE - per-channel state is ON
//               BUSY   - any channel in WAKE or DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
module obufds_gt_refclk_ctrl
    import obufds_gt_pkg::*;
#(
    parameter int                NUM_CH            = 4,
    parameter logic [NUM_CH-1:0] REFCLK_EN_TX_PATH = {NUM_CH{1'b1}},
    parameter int                SETTLE_CYCLES     = 16,
    parameter int                SYNC_STAGES       = 2
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              GTS,
    input  logic [NUM_CH-1:0] CEB,
    input  logic [NUM_CH-1:0] I,
    output logic [NUM_CH-1:0] O,
    output logic [NUM_CH-1:0] OB,
    output logic [NUM_CH-1:0] ACTIVE,
    output logic              BUSY
);

    logic [NUM_CH-1:0] w_busy;

    generate
        for (genvar g_idx = 0; g_idx < NUM_CH; g_idx++) begin : g_ch
            obufds_gt_ch #(
                .SETTLE_CYCLES (SETTLE_CYCLES),
                .SYNC_STAGES   (SYNC_STAGES),
                .TX_PATH_EN    (REFCLK_EN_TX_PATH[g_idx])
            ) u_ch (
                .clk      (CLK),
                .rst_n    (RSTB),
                .i_gts    (GTS),
                .i_ceb    (CEB[g_idx]),
                .i_refclk (I[g_idx]),
                .o_p      (O[g_idx]),
                .o_n      (OB[g_idx]),
                .o_active (ACTIVE[g_idx]),
                .o_busy   (w_busy[g_idx])
            );
        end
    endgenerate

    assign BUSY = |w_busy;

endmodule
`default_nettype wire

// File: tb/tb_obufds_gt_refclk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_obufds_gt_refclk_ctrl
// Description : Self-checking bench for obufds_gt_refclk_ctrl. Outputs are
//               pulled up, so a released pair reads O=OB=1 while a driven
//               pair is always complementary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obufds_gt_refclk_ctrl;

    logic       CLK   = 1'b0;
    logic       RSTB  = 1'b0;
    logic       rstb2 = 1'b0;
    logic       GTS   = 1'b0;
    logic [3:0] ceb   = 4'b1111;
    logic [3:0] ceb2  = 4'b0000;
    logic [3:0] tog_mask = 4'b1111;
    logic [3:0] i_man    = 4'b0000;
    logic [1:0] div      = 2'b00;
    wire  [3:0] i_drv;
    wire  [3:0] o_a, ob_a, act_a;
    wire        busy_a;
    wire  [3:0] o_b, ob_b, act_b;
    wire        busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) div <= div + 2'd1;

    // Free-running CLK/4 clock, or a hand-held level per channel.
    assign i_drv = (tog_mask & {4{div[1]}}) | (~tog_mask & i_man);

    generate
        for (genvar g_k = 0; g_k < 4; g_k++) begin : g_pu
            pullup (o_a[g_k]);
            pullup (ob_a[g_k]);
            pullup (o_b[g_k]);
            pullup (ob_b[g_k]);
        end
    endgenerate

    obufds_gt_refclk_ctrl #(
        .NUM_CH(4), .REFCLK_EN_TX_PATH(4'b1111), .SETTLE_CYCLES(16), .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK), .RSTB(RSTB), .GTS(GTS), .CEB(ceb), .I(i_drv),
        .O(o_a), .OB(ob_a), .ACTIVE(act_a), .BUSY(busy_a)
    );

    obufds_gt_refclk_ctrl #(
        .NUM_CH(4), .REFCLK_EN_TX_PATH(4'b0111), .SETTLE_CYCLES(16), .SYNC_STAGES(2)
    ) dut_mask (
        .CLK(CLK), .RSTB(rstb2), .GTS(1'b0), .CEB(ceb2), .I(i_drv),
        .O(o_b), .OB(ob_b), .ACTIVE(act_b), .BUSY(busy_b)
    );

    typedef struct {
        logic       gts;
        logic       i0;
        logic       adv;      // wait for a clock edge before checking
        logic [1:0] exp_oob;  // {O[0], OB[0]}
        logic       exp_act;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int ch, input bit drv);
        logic [1:0] a;
        logic [1:0] e;
        a = {o_a[ch], ob_a[ch]};
        e = drv ? {i_drv[ch], ~i_drv[ch]} : 2'b11;
        chk(name, 32'(a), 32'(e));
    endtask

    initial begin
        tbl[0] = '{gts: 1'b0, i0: 1'b0, adv: 1'b0, exp_oob: 2'b01, exp_act: 1'b1};
        tbl[1] = '{gts: 1'b0, i0: 1'b1, adv: 1'b1, exp_oob: 2'b10, exp_act: 1'b1};
        tbl[2] = '{gts: 1'b1, i0: 1'b1, adv: 1'b0, exp_oob: 2'b11, exp_act: 1'b1};
        tbl[3] = '{gts: 1'b1, i0: 1'b0, adv: 1'b1, exp_oob: 2'b11, exp_act: 1'b1};
        tbl[4] = '{gts: 1'b0, i0: 1'b0, adv: 1'b0, exp_oob: 2'b01, exp_act: 1'b1};
        tbl[5] = '{gts: 1'b0, i0: 1'b1, adv: 1'b1, exp_oob: 2'b10, exp_act: 1'b1};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_active", 32'(act_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        for (int c = 0; c < 4; c++) chk_out("rst_z", c, 1'b0);
        #2;
        RSTB  = 1'b1;
        rstb2 = 1'b1;
        tick();  // reference edge 0

        // Channel 0 bring-up latency: ON at edge 19, BUSY over edges 3..18
        ceb[0] = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 2) chk("wake_busy_e2", 32'(busy_a), 32'h0);
            if (e == 3) chk("wake_busy_e3", 32'(busy_a), 32'h1);
            if (e == 18) begin
                chk("wake_act_e18", 32'(act_a[0]), 32'h0);
                chk("wake_busy_e18", 32'(busy_a), 32'h1);
                chk_out("wake_z_e18", 0, 1'b0);
            end
            if (e == 19) begin
                chk("on_act_e19", 32'(act_a[0]), 32'h1);
                chk("on_busy_e19", 32'(busy_a), 32'h0);
                chk_out("on_drv_e19", 0, 1'b1);
            end
        end

        // Output path vectors with channel 0 ON
        tog_mask[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            GTS      = tbl[k].gts;
            i_man[0] = tbl[k].i0;
            if (tbl[k].adv) tick();
            else #1;
            chk($sformatf("vec%0d_oob", k), 32'({o_a[0], ob_a[0]}), 32'(tbl[k].exp_oob));
            chk($sformatf("vec%0d_act", k), 32'(act_a[0]), 32'(tbl[k].exp_act));
        end

        // GTS pulse for 10 cycles
        GTS = 1'b1;
        #1;
        chk_out("gts_z_now", 0, 1'b0);
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_out("gts_z", 0, 1'b0);
            chk("gts_act", 32'(act_a[0]), 32'h1);
        end
        GTS = 1'b0;
        #1;
        chk_out("gts_resume", 0, 1'b1);

        // Drain with I held high, then released low
        i_man[0] = 1'b1;
        ceb[0]   = 1'b1;
        repeat (3) tick();
        chk("drain_busy", 32'(busy_a), 32'h1);
        chk("drain_act", 32'(act_a[0]), 32'h0);
        chk_out("drain_drv", 0, 1'b1);
        repeat (2) tick();
        chk_out("drain_hold", 0, 1'b1);
        i_man[0] = 1'b0;
        #1;
        chk_out("drain_i0_drv", 0, 1'b1);
        tick();
        chk_out("drain_off_z", 0, 1'b0);
        chk("drain_off_busy", 32'(busy_a), 32'h0);

        // Re-request during DRAIN returns to ON with no gap
        ceb[0] = 1'b0;
        repeat (19) tick();
        chk("reon_act", 32'(act_a[0]), 32'h1);
        i_man[0] = 1'b1;
        ceb[0]   = 1'b1;
        repeat (3) tick();
        chk("redrain_busy", 32'(busy_a), 32'h1);
        ceb[0] = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk_out("redrain_nogap", 0, 1'b1);
        end
        chk("redrain_act", 32'(act_a[0]), 32'h1);
        chk("redrain_busy_end", 32'(busy_a), 32'h0);

        // Channel 2 drain timeout with I stuck high
        ceb[2] = 1'b0;
        repeat (19) tick();
        chk("ch2_act", 32'(act_a[2]), 32'h1);
        tog_mask[2] = 1'b0;
        i_man[2]    = 1'b1;
        ceb[2]      = 1'b1;
        repeat (3) tick();
        chk("ch2_drain_busy", 32'(busy_a), 32'h1);
        repeat (15) tick();
        chk_out("ch2_drv_15", 2, 1'b1);
        tick();
        chk_out("ch2_timeout_z", 2, 1'b0);
        chk("ch2_timeout_busy", 32'(busy_a), 32'h0);
        tog_mask[2] = 1'b1;

        // Channel 1 aborted wake never drives
        ceb[1] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk_out("abort_z_low", 1, 1'b0);
        end
        chk("abort_busy_wake", 32'(busy_a), 32'h1);
        ceb[1] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk_out("abort_z_high", 1, 1'b0);
        end
        chk("abort_busy_off", 32'(busy_a), 32'h0);
        chk("abort_act", 32'(act_a[1]), 32'h0);

        // Simultaneous requests on channels 1 and 3
        ceb[1] = 1'b0;
        ceb[3] = 1'b0;
        repeat (18) tick();
        chk("multi_act_e18", 32'(act_a), 32'h1);
        tick();
        chk("multi_act_e19", 32'(act_a), 32'hb);

        // Asynchronous reset mid-WAKE on channel 2
        ceb[2] = 1'b0;
        repeat (6) tick();
        chk("pre_rst_busy", 32'(busy_a), 32'h1);
        #2;
        RSTB = 1'b0;
        #1;
        chk("arst_active", 32'(act_a), 32'h0);
        chk("arst_busy", 32'(busy_a), 32'h0);
        for (int c = 0; c < 4; c++) chk_out("arst_z", c, 1'b0);
        tick();
        chk("arst_hold_act", 32'(act_a), 32'h0);
        #3;
        RSTB = 1'b1;
        tick();
        chk("rel_busy_e1", 32'(busy_a), 32'h0);
        tick();
        chk("rel_busy_e2", 32'(busy_a), 32'h0);
        tick();
        chk("rel_busy_e3", 32'(busy_a), 32'h1);

        // Masked channel 3 on the second instance never drives
        chk("mask_o3", 32'({o_b[3], ob_b[3]}), 32'h3);
        chk("mask_act", 32'(act_b), 32'h7);
        chk("mask_busy", 32'(busy_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
